// File: rtl/reverb_pkg.sv
// Shared types and default sizes for the reverb block packer.
package reverb_pkg;

    localparam int REVERB_SAMPLE_W  = 16;
    localparam int REVERB_BLOCK_LEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_STREAM,
        ST_DRAIN
    } packer_state_t;

endpackage

// File: rtl/reverb_block_packer_buf.sv
// Show-ahead FIFO: o_data is the registered head entry while not empty.
module reverb_block_packer_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A pop on the same edge frees the slot the push needs.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reverb_block_packer.sv
// Packs stereo codec samples into aligned blocks on an Avalon-ST source.
// Define REVERB_PACKER_OVERRUN_CNT_EN to build the dropped-sample counter.
module reverb_block_packer
    import reverb_pkg::*;
#(
    parameter int BLOCK_LEN = REVERB_BLOCK_LEN,
    parameter int SAMPLE_W  = REVERB_SAMPLE_W,
    parameter int BUF_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   left_in,
    input  logic [SAMPLE_W-1:0]   right_in,
    output logic [2*SAMPLE_W-1:0] src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  block_done,
    output logic                  overrun,
    output logic [15:0]           overrun_cnt
);

    localparam int IW = $clog2(BLOCK_LEN);

    packer_state_t r_state;
    packer_state_t w_state_nxt;
    logic [IW-1:0] r_index;
    logic          r_block_done;
    logic          r_overrun;
    logic          w_wr_req;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic          w_last;

    assign w_last = (r_index == IW'(BLOCK_LEN - 1));
    assign w_pop  = src_valid && src_ready;
    assign w_push = w_wr_req && (!w_full || w_pop);
    assign w_drop = w_wr_req && w_full && !w_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:
                if (enable) w_state_nxt = ST_ARM;
            ST_ARM:
                if (!enable)     w_state_nxt = ST_IDLE;
                else if (w_push) w_state_nxt = ST_STREAM;
            ST_STREAM:
                if (w_push && w_last)
                    w_state_nxt = enable ? ST_STREAM : ST_IDLE;
                else if (!enable)
                    w_state_nxt = (r_index == '0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN:
                if (w_push && w_last) w_state_nxt = ST_IDLE;
                else if (enable)      w_state_nxt = ST_STREAM;
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    // A block boundary with enable low never opens a new block.
    always_comb begin
        w_wr_req = 1'b0;
        unique case (r_state)
            ST_ARM:    w_wr_req = sample_valid && enable;
            ST_STREAM: w_wr_req = sample_valid && (enable || r_index != '0);
            ST_DRAIN:  w_wr_req = sample_valid;
            default:   w_wr_req = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_index      <= '0;
            r_block_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_block_done <= w_push && w_last;
            if (w_push) r_index <= r_index + IW'(1);
            if (w_drop) r_overrun <= 1'b1;
        end
    end

`ifdef REVERB_PACKER_OVERRUN_CNT_EN
    logic [15:0] r_overrun_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_overrun_cnt <= '0;
        else if (w_drop && r_overrun_cnt != 16'hFFFF)
            r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end

    assign overrun_cnt = r_overrun_cnt;
`else
    assign overrun_cnt = '0;
`endif

    assign block_done = r_block_done;
    assign overrun    = r_overrun;
    assign src_valid  = !w_empty;

    reverb_block_packer_buf #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  ({left_in, right_in}),
        .i_pop   (w_pop),
        .o_data  (src_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_reverb_block_packer.sv
// Directed bench for reverb_block_packer with default parameters.
module tb_reverb_block_packer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        src_ready = 1'b0;
    logic [31:0] src_data;
    logic        src_valid;
    logic        block_done;
    logic        overrun;
    logic [15:0] overrun_cnt;

`ifdef REVERB_PACKER_OVERRUN_CNT_EN
    localparam logic [15:0] CNT_AFTER_37 = 16'd2;
    localparam logic [15:0] CNT_AFTER_38 = 16'd3;
`else
    localparam logic [15:0] CNT_AFTER_37 = 16'd0;
    localparam logic [15:0] CNT_AFTER_38 = 16'd0;
`endif

    reverb_block_packer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .left_in      (left_in),
        .right_in     (right_in),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .block_done   (block_done),
        .overrun      (overrun),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    int          bd_cnt = 0;
    int          bd_at = 0;
    int          wr_cnt = 0;
    logic [31:0] rx[$];
    logic [31:0] expq[$];

    typedef struct {
        logic        sv;
        logic        rdy;
        logic [15:0] smp;
        logic        ev;
        logic [31:0] ed;
        logic        eo;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        if (src_valid && src_ready) rx.push_back(src_data);
        @(posedge clock);
        #1;
        if (block_done) begin
            bd_cnt++;
            bd_at = wr_cnt;
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        sample_valid = 1'b1;
        left_in      = l;
        right_in     = r;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        enable       = 1'b0;
        sample_valid = 1'b0;
        src_ready    = 1'b0;
        reset_n      = 1'b0;
        #12;
        reset_n = 1'b1;
        step();
        rx.delete();
        bd_cnt = 0;
        bd_at  = 0;
        wr_cnt = 0;
    endtask

    initial begin
        logic [15:0] v;
        logic [31:0] prev;
        logic        stall;
        int          k;

        tbl[0] = '{1'b1, 1'b0, 16'h0001, 1'b1, 32'h00010001, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0002, 1'b1, 32'h00010001, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h0003, 1'b1, 32'h00010001, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h0004, 1'b1, 32'h00010001, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'h0005, 1'b1, 32'h00010001, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 16'h0006, 1'b1, 32'h00010001, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b1, 32'h00020002, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 16'h0000, 1'b1, 32'h00030003, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 16'h0000, 1'b1, 32'h00040004, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 16'h0000, 1'b0, 32'h00000000, 1'b1};

        // reset state
        #3;
        chk("rst_valid", 32'(src_valid), 32'd0);
        chk("rst_data", src_data, 32'd0);
        chk("rst_block_done", 32'(block_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);

        // full block, continuous ready
        do_reset();
        enable    = 1'b1;
        src_ready = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            v = 16'(i);
            wr_cnt++;
            send(v, ~v);
        end
        repeat (3) step();
        chk("blk_words", 32'(rx.size()), 32'd64);
        for (int i = 0; i < 64 && i < rx.size(); i++) begin
            v = 16'(i);
            chk("blk_word", rx[i], {v, ~v});
        end
        chk("blk_done_cnt", 32'(bd_cnt), 32'd1);
        chk("blk_done_at", 32'(bd_at), 32'd64);

        // enable drops after sample 10: block completes, then idle
        do_reset();
        enable    = 1'b1;
        src_ready = 1'b1;
        step();
        for (int i = 0; i < 70; i++) begin
            if (i == 10) enable = 1'b0;
            if (i < 64) wr_cnt++;
            v = 16'(i);
            send(v, 16'hA000 + v);
        end
        repeat (3) step();
        chk("drain_words", 32'(rx.size()), 32'd64);
        if (rx.size() == 64) begin
            chk("drain_first", rx[0], 32'h0000A000);
            chk("drain_w10", rx[10], 32'h000AA00A);
            chk("drain_last", rx[63], 32'h003FA03F);
        end
        chk("drain_done_cnt", 32'(bd_cnt), 32'd1);
        chk("drain_done_at", 32'(bd_at), 32'd64);
        for (int i = 0; i < 5; i++) send(16'hBEEF, 16'h1234);
        repeat (3) step();
        chk("idle_discard", 32'(rx.size()), 32'd64);

        // stalled sink: fill, drop, then drain in order
        do_reset();
        enable = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            sample_valid = tbl[i].sv;
            left_in      = tbl[i].smp;
            right_in     = tbl[i].smp;
            src_ready    = tbl[i].rdy;
            step();
            chk($sformatf("ovr_valid[%0d]", i), 32'(src_valid), 32'(tbl[i].ev));
            if (tbl[i].ev)
                chk($sformatf("ovr_data[%0d]", i), src_data, tbl[i].ed);
            chk($sformatf("ovr_flag[%0d]", i), 32'(overrun), 32'(tbl[i].eo));
        end
        sample_valid = 1'b0;
        chk("ovr_cnt", 32'(overrun_cnt), 32'(CNT_AFTER_37));
        chk("ovr_rx_len", 32'(rx.size()), 32'd4);

        // full buffer with simultaneous push and pop
        rx.delete();
        src_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            v = 16'h0010 + 16'(i);
            send(v, v);
        end
        src_ready = 1'b1;
        send(16'h0015, 16'h0015);
        chk("full_rw_cnt", 32'(overrun_cnt), 32'(CNT_AFTER_37));
        src_ready = 1'b0;
        send(16'h0016, 16'h0016);
        chk("full_drop_cnt", 32'(overrun_cnt), 32'(CNT_AFTER_38));
        src_ready = 1'b1;
        repeat (6) step();
        chk("full_rx_len", 32'(rx.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx.size(); i++) begin
            v = 16'h0011 + 16'(i);
            chk("full_rx", rx[i], {v, v});
        end

        // asynchronous reset mid-block
        do_reset();
        enable    = 1'b1;
        src_ready = 1'b1;
        step();
        for (int i = 0; i < 30; i++) send(16'(i), 16'(i));
        src_ready = 1'b0;
        send(16'h001E, 16'h001E);
        chk("mid_valid_pre", 32'(src_valid), 32'd1);
        enable  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_valid_rst", 32'(src_valid), 32'd0);
        chk("mid_data_rst", src_data, 32'd0);
        #3;
        reset_n = 1'b1;
        step();
        rx.delete();
        bd_cnt = 0;
        wr_cnt = 0;
        enable    = 1'b1;
        src_ready = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            wr_cnt++;
            send(16'h0400 + 16'(i), 16'h0);
            if (i == 62) chk("mid_no_early_done", 32'(bd_cnt), 32'd0);
        end
        repeat (3) step();
        chk("mid_done_cnt", 32'(bd_cnt), 32'd1);
        chk("mid_done_at", 32'(bd_at), 32'd64);
        chk("mid_rx_len", 32'(rx.size()), 32'd64);
        if (rx.size() > 0) chk("mid_rx_first", rx[0], 32'h04000000);

        // ready toggling every cycle
        do_reset();
        enable = 1'b1;
        step();
        expq.delete();
        k = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            src_ready    = cyc[0];
            sample_valid = (cyc % 3 == 0);
            if (sample_valid) begin
                left_in  = 16'h0300 + 16'(k);
                right_in = 16'h00C0 + 16'(k);
                expq.push_back({left_in, right_in});
                k++;
            end
            stall = src_valid && !src_ready;
            prev  = src_data;
            step();
            if (stall) begin
                chk("tog_stall_valid", 32'(src_valid), 32'd1);
                chk("tog_stall_data", src_data, prev);
            end
        end
        sample_valid = 1'b0;
        src_ready    = 1'b1;
        repeat (6) step();
        chk("tog_rx_len", 32'(rx.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < rx.size(); i++)
            chk("tog_rx", rx[i], expq[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
